// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the multi-cycle core and its instruction-phase sequencer.
// master drives the control levels; slave is the sequencer.
interface phase_sequencer_if #(
   parameter int ICNT_W = 16
);
   logic              start;
   logic              halt_req;
   logic              hlt_op;
   logic              step_mode;
   logic              mem_wait;
   logic [2:0]        phase;
   logic              run;
   logic              halted;
   logic              ir_we;
   logic              pc_we;
   logic [ICNT_W-1:0] instr_cnt;

   modport master (
      output start, halt_req, hlt_op, step_mode, mem_wait,
      input  phase, run, halted, ir_we, pc_we, instr_cnt
   );

   modport slave (
      input  start, halt_req, hlt_op, step_mode, mem_wait,
      output phase, run, halted, ir_we, pc_we, instr_cnt
   );
endinterface

// File: rtl/phase_sequencer.sv
// Steps each instruction through fetch..writeback, stretches the memory phase on mem_wait,
// stops at instruction boundaries for halt/pause/single-step and counts retired instructions.
module phase_sequencer #(
   parameter logic [2:0] LAST_PHASE = 3'b100,
   parameter logic [2:0] MEM_PHASE  = 3'b011,
   parameter int         ICNT_W     = 16
) (
   input  logic             clock,
   input  logic             rst,
   phase_sequencer_if.slave bus
);

   localparam logic [2:0] FETCH_PHASE  = 3'b000;
   localparam logic [2:0] DECODE_PHASE = 3'b001;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      HALT
   } state_t;

   state_t            state;
   logic [2:0]        phase_q;
   logic              run_q;
   logic              halted_q;
   logic [ICNT_W-1:0] cnt_q;

   // NOTE: non-blocking assignments throughout, so every register sees pre-edge values
   // regardless of statement order; blocking here would chain updates within one edge.
   always_ff @(posedge clock) begin
      if (rst) begin
         state    <= IDLE;
         phase_q  <= FETCH_PHASE;
         run_q    <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state)
            IDLE, PAUSE: begin
               if (bus.start) begin
                  state   <= RUN;
                  run_q   <= 1'b1;
                  phase_q <= FETCH_PHASE;
               end
            end

            RUN: begin
               if (phase_q == DECODE_PHASE && bus.hlt_op) begin
                  // Halt instruction never reaches writeback, so it is not retired.
                  state    <= HALT;
                  run_q    <= 1'b0;
                  halted_q <= 1'b1;
                  phase_q  <= FETCH_PHASE;
               end else if (phase_q == LAST_PHASE) begin
                  cnt_q   <= cnt_q + ICNT_W'(1);
                  phase_q <= FETCH_PHASE;
                  if (bus.halt_req || bus.step_mode) begin
                     state <= PAUSE;
                     run_q <= 1'b0;
                  end
               end else if (!(phase_q == MEM_PHASE && bus.mem_wait)) begin
                  phase_q <= phase_q + 3'd1;
               end
            end

            HALT: begin
               phase_q <= FETCH_PHASE;
            end

            default: begin
               state   <= IDLE;
               run_q   <= 1'b0;
               phase_q <= FETCH_PHASE;
            end
         endcase
      end
   end

   // Write enables are pure decodes of registered state, so they reset with it.
   assign bus.ir_we     = run_q && (phase_q == FETCH_PHASE);
   assign bus.pc_we     = run_q && (phase_q == LAST_PHASE);
   assign bus.phase     = phase_q;
   assign bus.run       = run_q;
   assign bus.halted    = halted_q;
   assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: default-width instance for sequencing behaviour,
// a 4-bit-counter instance for the wrap case.
module tb_phase_sequencer;

   logic clock = 1'b0;
   logic rst   = 1'b1;

   int n_checks = 0;
   int n_errors = 0;
   int pulses_a = 0;

   always #5 clock = ~clock;

   phase_sequencer_if #(.ICNT_W(16)) bus_a ();
   phase_sequencer_if #(.ICNT_W(4))  bus_b ();

   phase_sequencer #(.ICNT_W(16)) dut_a (
      .clock (clock),
      .rst   (rst),
      .bus   (bus_a)
   );

   phase_sequencer #(.ICNT_W(4)) dut_b (
      .clock (clock),
      .rst   (rst),
      .bus   (bus_b)
   );

   always @(negedge clock) begin
      if (bus_a.pc_we) pulses_a++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic check_a(input string tag, input int ph, input int rn, input int hl, input int cnt);
      check({tag, "_phase"},  32'(bus_a.phase),     32'(ph));
      check({tag, "_run"},    32'(bus_a.run),       32'(rn));
      check({tag, "_halted"}, 32'(bus_a.halted),    32'(hl));
      check({tag, "_cnt"},    32'(bus_a.instr_cnt), 32'(cnt));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      int len;
      int n3;
      int p0;

      bus_a.start = 0; bus_a.halt_req = 0; bus_a.hlt_op = 0; bus_a.step_mode = 0; bus_a.mem_wait = 0;
      bus_b.start = 0; bus_b.halt_req = 0; bus_b.hlt_op = 0; bus_b.step_mode = 0; bus_b.mem_wait = 0;

      // Reset values
      do_reset();
      check_a("rst", 0, 0, 0, 0);
      check("rst_ir_we", 32'(bus_a.ir_we), 32'd0);
      check("rst_pc_we", 32'(bus_a.pc_we), 32'd0);
      check("rst_b_cnt", 32'(bus_b.instr_cnt), 32'd0);

      // Three unstalled instructions
      bus_a.start = 1;
      cyc();
      bus_a.start = 0;
      check("t1_ir_we", 32'(bus_a.ir_we), 32'd1);
      for (int i = 0; i < 15; i++) begin
         check("t1_phase", 32'(bus_a.phase), 32'(i % 5));
         check("t1_pc_we", 32'(bus_a.pc_we), 32'((i % 5) == 4));
         cyc();
      end
      check_a("t1_end", 0, 1, 0, 3);

      // mem_wait for 4 cycles at phase 3; a mem_wait at phase 1 must be ignored
      len = 0;
      n3  = 0;
      p0  = pulses_a;
      for (int i = 0; i < 20; i++) begin
         len++;
         if (bus_a.phase == 3'd3) n3++;
         bus_a.mem_wait = (bus_a.phase == 3'd1) || (bus_a.phase == 3'd3 && n3 <= 4);
         cyc();
         if (bus_a.phase == 3'd0) break;
      end
      bus_a.mem_wait = 0;
      check("t2_len", 32'(len), 32'd9);
      check("t2_phase3_cycles", 32'(n3), 32'd5);
      check("t2_pc_pulses", 32'(pulses_a - p0), 32'd1);
      check_a("t2_end", 0, 1, 0, 4);

      // hlt_op outside phase 1 and halt_req only at phase 2 are both ignored
      bus_a.hlt_op = 1;
      cyc();
      bus_a.hlt_op = 0;
      cyc();
      bus_a.halt_req = 1;
      cyc();
      bus_a.halt_req = 0;
      check_a("t5_mid", 3, 1, 0, 4);
      cyc();
      cyc();
      check_a("t5_ignored", 0, 1, 0, 5);

      // halt_req from phase 1 through writeback pauses after retirement
      cyc();
      bus_a.halt_req = 1;
      cyc();
      cyc();
      cyc();
      check("t5_pc_we", 32'(bus_a.pc_we), 32'd1);
      cyc();
      check_a("t5_pause", 0, 0, 0, 6);
      bus_a.halt_req = 0;
      cyc();
      cyc();
      check_a("t5_hold", 0, 0, 0, 6);
      bus_a.start = 1;
      cyc();
      bus_a.start = 0;
      check_a("t5_resume", 0, 1, 0, 6);
      check("t5_resume_ir_we", 32'(bus_a.ir_we), 32'd1);

      // hlt_op in phase 1 of the 2nd instruction
      do_reset();
      p0 = pulses_a;
      bus_a.start = 1;
      cyc();
      bus_a.start = 0;
      repeat (5) cyc();
      check_a("t3_first", 0, 1, 0, 1);
      cyc();
      bus_a.hlt_op = 1;
      cyc();
      bus_a.hlt_op = 0;
      check_a("t3_halt", 0, 0, 1, 1);
      check("t3_pc_we", 32'(bus_a.pc_we), 32'd0);
      check("t3_pc_pulses", 32'(pulses_a - p0), 32'd1);
      bus_a.start = 1;
      cyc();
      cyc();
      bus_a.start = 0;
      check_a("t3_start_ignored", 0, 0, 1, 1);
      do_reset();
      check_a("t3_rst", 0, 0, 0, 0);

      // Single-step: one instruction per start pulse; start during RUN ignored
      bus_a.step_mode = 1;
      for (int k = 0; k < 3; k++) begin
         bus_a.start = 1;
         cyc();
         bus_a.start = 0;
         check_a("t4_go", 0, 1, 0, k);
         cyc();
         cyc();
         bus_a.start = 1;
         cyc();
         bus_a.start = 0;
         cyc();
         check("t4_pc_we", 32'(bus_a.pc_we), 32'd1);
         cyc();
         check_a("t4_pause", 0, 0, 0, k + 1);
         cyc();
         check_a("t4_idle", 0, 0, 0, k + 1);
      end
      bus_a.step_mode = 0;

      // 4-bit counter wraps on the 16th instruction
      do_reset();
      bus_b.start = 1;
      cyc();
      bus_b.start = 0;
      repeat (75) cyc();
      check("t6_cnt15", 32'(bus_b.instr_cnt), 32'd15);
      check("t6_phase0", 32'(bus_b.phase), 32'd0);
      repeat (4) cyc();
      check("t6_pc_we", 32'(bus_b.pc_we), 32'd1);
      cyc();
      check("t6_wrap", 32'(bus_b.instr_cnt), 32'd0);
      check("t6_run", 32'(bus_b.run), 32'd1);

      // Reset during a mem_wait stall
      bus_a.start = 1;
      cyc();
      bus_a.start = 0;
      cyc();
      cyc();
      cyc();
      bus_a.mem_wait = 1;
      cyc();
      cyc();
      check("t7_stall", 32'(bus_a.phase), 32'd3);
      rst = 1;
      cyc();
      rst = 0;
      bus_a.mem_wait = 0;
      check_a("t7_rst", 0, 0, 0, 0);
      check("t7_ir_we", 32'(bus_a.ir_we), 32'd0);
      check("t7_pc_we", 32'(bus_a.pc_we), 32'd0);
      check("t7_b_cnt", 32'(bus_b.instr_cnt), 32'd0);
      cyc();
      check("t7_pc_we_after", 32'(bus_a.pc_we), 32'd0);
      check_a("t7_after", 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Instruction-phase sequencer for the multi-cycle core: generates the 3-bit `phase` bus consumed by the program counter, instruction register and register file. It steps each instruction through fetch → decode → execute → memory → writeback, stretches the memory phase on `mem_wait`, and stops at instruction boundaries for halt instructions, external halt requests and single-step mode. It also keeps a retired-instruction counter.

## Interface

- `LAST_PHASE`, default 3'b100: writeback phase. Phase counts 000..LAST_PHASE; the program counter advances in this phase.
- `MEM_PHASE`, default 3'b011: the only phase that `mem_wait` can stretch.
- `ICNT_W`, default 16: width of the retired-instruction counter.

- `clock`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: level; moves IDLE or PAUSE to RUN.
- `halt_req`  in  1: level; external pause request, honored only at writeback.
- `hlt_op`  in  1: decoded halt instruction, sampled only in phase 001.
- `step_mode`  in  1: level; when 1, pause after every retired instruction.
- `mem_wait`  in  1: level; holds phase at MEM_PHASE while 1.
- `phase`  out  3: current phase, registered.
- `run`  out  1: 1 while in RUN, registered.
- `halted`  out  1: 1 while in HALT, registered.
- `ir_we`  out  1: `run & (phase==000)`, decoded from registers.
- `pc_we`  out  1: `run & (phase==LAST_PHASE)`, decoded from registers.
- `instr_cnt`  out  ICNT_W: count of retired instructions, registered.

## Operation

- There are four states: IDLE, RUN, PAUSE and HALT.
- In IDLE, PAUSE and HALT, `phase` is held at 000.
- IDLE → RUN when `start` = 1.
- PAUSE → RUN when `start` = 1.
- HALT is exited only by `rst`; `start` is ignored in HALT.
- In RUN, phase advances by 1 each cycle, with these exceptions:
  - At MEM_PHASE with `mem_wait` = 1, phase holds.
  - At LAST_PHASE, phase returns to 000.
- RUN, phase 001, `hlt_op` = 1:
  - Next state is HALT and phase goes to 000.
  - Writeback is never reached, so `pc_we` never pulses for the halt instruction and `instr_cnt` is not incremented.
- RUN, phase LAST_PHASE:
  - `instr_cnt` increments and phase goes to 000.
  - If `halt_req` or `step_mode` is 1, next state is PAUSE; otherwise RUN continues.
- Phase is never held at LAST_PHASE for more than one cycle. The program counter increments on every cycle it sees LAST_PHASE, so a hold would cause extra increments.
- Inputs outside their sampling window are ignored:
  - `hlt_op` outside phase 001.
  - `mem_wait` outside MEM_PHASE.
  - `halt_req` outside LAST_PHASE.
  - `start` while in RUN or HALT.
- Priority: `rst` > `hlt_op` > `halt_req`/`step_mode`. Only one of these can be sampled per phase, so no other conflicts exist.
- `instr_cnt` wraps from 2^ICNT_W−1 to 0 with no flag.

## Timing

- Reset values: state IDLE, `phase` 000, `run` 0, `halted` 0, `instr_cnt` 0, `ir_we` 0, `pc_we` 0.
- `start` high at edge N: `run` = 1 and `phase` = 000 after edge N. `ir_we` is high in the cycle following edge N.
- With no stalls, one instruction takes LAST_PHASE+1 = 5 cycles; `pc_we` pulses exactly once per instruction.
- Each cycle `mem_wait` is high at MEM_PHASE adds exactly one cycle to the instruction.
- Entering PAUSE or HALT: `run` drops and `phase` is 000 in the cycle after the deciding edge.
- `halted` rises in the same cycle `run` drops.
- Resume from PAUSE: `start` at edge N gives phase 000 with `run` = 1 after edge N.
- `rst` mid-instruction, including during a `mem_wait` stall:
  - All outputs take their reset values after the edge.
  - No `pc_we` pulse occurs in the cycle after reset.

## Test plan

- Reset, pulse `start`, run 3 instructions with no stalls: `phase` sequence 0,1,2,3,4 repeats; `pc_we` high on cycles 5, 10 and 15 after start; `instr_cnt` = 3.
- Hold `mem_wait` = 1 for 4 cycles at phase 011: phase holds at 3 for 5 cycles total; the instruction takes 9 cycles; exactly one `pc_we` pulse.
- Assert `hlt_op` at phase 001 of the 2nd instruction: `halted` = 1, `phase` = 000, `instr_cnt` = 1, only one `pc_we` pulse seen; a later `start` is ignored; only `rst` clears `halted`.
- `step_mode` = 1, pulse `start` 3 times: one instruction per pulse, PAUSE between pulses, `instr_cnt` = 3; `start` pulses during RUN have no effect.
- `halt_req` high from phase 001 through 100: PAUSE after that instruction's writeback; `halt_req` high only at phase 010: no effect.
- `instr_cnt` preset near wrap via ICNT_W = 4: the 16th instruction wraps the count to 0; `rst` during a stall at phase 011: all outputs reset on the next cycle.
